// File: rtl/pipe_hazard_ctrl.sv
// Sequencing controller for the PC/FD/DE/EM registers: memory freeze, branch flush and load-use stall.
// Enables/flushes are combinational from state and inputs; state and statistics are registered.
module pipe_hazard_ctrl #(
    parameter int unsigned MEM_WAIT = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [3:0]  decode_rs1_i,
    input  logic [3:0]  decode_rs2_i,
    input  logic        decode_use1_i,
    input  logic        decode_use2_i,
    input  logic [3:0]  execute_rd_i,
    input  logic        execute_mem2reg_i,
    input  logic        branch_taken_i,
    input  logic        mem_start_i,
    output logic        pc_write_o,
    output logic        fd_write_o,
    output logic        de_write_o,
    output logic        em_write_o,
    output logic        fd_flush_o,
    output logic        de_flush_o,
    output logic [1:0]  ctrl_state_o,
    output logic [15:0] stall_cycles_o,
    output logic [7:0]  flush_count_o
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        WAIT    = 2'd1,
        RELEASE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        M_NORMAL,
        M_FREEZE,
        M_BRANCH,
        M_LOADUSE
    } mode_e;

    localparam logic [3:0] MW = 4'(MEM_WAIT);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] stall_q;
    logic [7:0]  flush_q;
    mode_e       mode;
    logic        load_use;

    assign load_use = execute_mem2reg_i && (execute_rd_i != 4'd0) &&
                      ((decode_use1_i && (decode_rs1_i == execute_rd_i)) ||
                       (decode_use2_i && (decode_rs2_i == execute_rd_i)));

    always_comb begin
        mode    = M_NORMAL;
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                if (mem_start_i && (MW != 4'd0)) begin
                    mode    = M_FREEZE;
                    cnt_d   = MW - 4'd1;
                    state_d = (MW == 4'd1) ? RELEASE : WAIT;
                end else if (branch_taken_i) begin
                    mode = M_BRANCH;
                end else if (load_use) begin
                    mode = M_LOADUSE;
                end
            end
            WAIT: begin
                mode = M_FREEZE;
                if (cnt_q <= 4'd1) begin
                    state_d = RELEASE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RELEASE: begin
                // mem_start is ignored here; a held request re-triggers from RUN
                if (branch_taken_i) begin
                    mode = M_BRANCH;
                end else if (load_use) begin
                    mode = M_LOADUSE;
                end
                state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        pc_write_o = 1'b1;
        fd_write_o = 1'b1;
        de_write_o = 1'b1;
        em_write_o = 1'b1;
        fd_flush_o = 1'b0;
        de_flush_o = 1'b0;
        if (rst_i) begin
            pc_write_o = 1'b0;
            fd_write_o = 1'b0;
            de_write_o = 1'b0;
            em_write_o = 1'b0;
            fd_flush_o = 1'b1;
            de_flush_o = 1'b1;
        end else begin
            case (mode)
                M_FREEZE: begin
                    pc_write_o = 1'b0;
                    fd_write_o = 1'b0;
                    de_write_o = 1'b0;
                    em_write_o = 1'b0;
                end
                M_BRANCH: begin
                    fd_flush_o = 1'b1;
                    de_flush_o = 1'b1;
                end
                M_LOADUSE: begin
                    pc_write_o = 1'b0;
                    fd_write_o = 1'b0;
                    de_flush_o = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= RUN;
            cnt_q   <= 4'd0;
            stall_q <= 16'd0;
            flush_q <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (!pc_write_o && (stall_q != 16'hFFFF)) begin
                stall_q <= stall_q + 16'd1;
            end
            if ((mode == M_BRANCH) && (flush_q != 8'hFF)) begin
                flush_q <= flush_q + 8'd1;
            end
        end
    end

    assign ctrl_state_o   = state_q;
    assign stall_cycles_o = stall_q;
    assign flush_count_o  = flush_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomised and directed stimulus for pipe_hazard_ctrl, checked via a queue-based scoreboard
// against a freeze-countdown reference model.
module tb_pipe_hazard_ctrl;

    localparam int MW = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  rs1, rs2, rd;
    logic        use1, use2, mem2reg, br, ms;
    logic        pc_w, fd_w, de_w, em_w, fd_fl, de_fl;
    logic [1:0]  st;
    logic [15:0] stall_cnt;
    logic [7:0]  flush_cnt;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MEM_WAIT(MW)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .decode_rs1_i      (rs1),
        .decode_rs2_i      (rs2),
        .decode_use1_i     (use1),
        .decode_use2_i     (use2),
        .execute_rd_i      (rd),
        .execute_mem2reg_i (mem2reg),
        .branch_taken_i    (br),
        .mem_start_i       (ms),
        .pc_write_o        (pc_w),
        .fd_write_o        (fd_w),
        .de_write_o        (de_w),
        .em_write_o        (em_w),
        .fd_flush_o        (fd_fl),
        .de_flush_o        (de_fl),
        .ctrl_state_o      (st),
        .stall_cycles_o    (stall_cnt),
        .flush_count_o     (flush_cnt)
    );

    typedef struct packed {
        logic [3:0]  wr;     // pc, fd, de, em
        logic [1:0]  fl;     // fd, de
        logic [1:0]  st;
        logic [15:0] stall;
        logic [7:0]  flc;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: freeze cycles still to come after this one, and a pending release slot.
    int m_wait_left = 0;
    bit m_rel = 0;
    int m_stall = 0;
    int m_flush = 0;

    task automatic cyc(input bit r, input bit m_s, input bit b, input bit ld,
                       input bit u1, input bit u2,
                       input logic [3:0] s1, input logic [3:0] s2, input logic [3:0] d);
        exp_t e;
        bit   lu, freeze, may_hz;
        rst = r; ms = m_s; br = b; mem2reg = ld;
        use1 = u1; use2 = u2; rs1 = s1; rs2 = s2; rd = d;
        e.st    = (m_wait_left > 0) ? 2'd1 : (m_rel ? 2'd2 : 2'd0);
        e.stall = 16'(m_stall);
        e.flc   = 8'(m_flush);
        lu = ld && (d != 0) && ((u1 && s1 == d) || (u2 && s2 == d));
        if (r) begin
            e.wr = 4'b0000; e.fl = 2'b11;
            m_wait_left = 0; m_rel = 0; m_stall = 0; m_flush = 0;
        end else begin
            freeze = 0;
            may_hz = 1;
            if (m_wait_left > 0) begin
                freeze = 1;
                m_wait_left--;
            end else if (m_rel) begin
                m_rel = 0;
            end else if (m_s && MW != 0) begin
                freeze = 1;
                m_wait_left = MW - 1;
                m_rel = 1;
            end
            if (freeze) begin
                e.wr = 4'b0000; e.fl = 2'b00;
                if (m_stall < 65535) m_stall++;
            end else if (b && may_hz) begin
                e.wr = 4'b1111; e.fl = 2'b11;
                if (m_flush < 255) m_flush++;
            end else if (lu && may_hz) begin
                e.wr = 4'b0011; e.fl = 2'b01;
                if (m_stall < 65535) m_stall++;
            end else begin
                e.wr = 4'b1111; e.fl = 2'b00;
            end
        end
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: outputs are presented every cycle; compare at the falling edge.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e, a;
            e = q.pop_front();
            a.wr = {pc_w, fd_w, de_w, em_w};
            a.fl = {fd_fl, de_fl};
            a.st = st;
            a.stall = stall_cnt;
            a.flc = flush_cnt;
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL outputs t=%0t: got wr=%b fl=%b st=%0d stall=%h flc=%h, exp wr=%b fl=%b st=%0d stall=%h flc=%h",
                         $time, a.wr, a.fl, a.st, a.stall, a.flc, e.wr, e.fl, e.st, e.stall, e.flc);
            end
        end
    end

    initial begin
        rst = 1; ms = 0; br = 0; mem2reg = 0; use1 = 0; use2 = 0;
        rs1 = 0; rs2 = 0; rd = 0;
        @(posedge clk);
        #1;

        // Reset then idle
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(3);

        // Load-use on rs2, then the two non-hazard variants
        cyc(0, 0, 0, 1, 0, 1, 4'd0, 4'd5, 4'd5);
        idle(1);
        cyc(0, 0, 0, 1, 0, 1, 4'd0, 4'd0, 4'd0);
        cyc(0, 0, 0, 1, 0, 0, 4'd0, 4'd5, 4'd5);
        cyc(0, 0, 0, 1, 1, 0, 4'd7, 4'd0, 4'd7);
        idle(1);

        // Freeze with branch held in execute until the release cycle
        cyc(0, 1, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < MW; i++) cyc(0, 0, 1, 0, 0, 0, 0, 0, 0);
        idle(2);

        // Branch beats load-use
        cyc(0, 0, 1, 1, 1, 1, 4'd3, 4'd3, 4'd3);
        idle(1);

        // Reset during the second WAIT cycle, then held mem_start retriggers
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2 * (MW + 1) + 1; i++) cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
        idle(2);

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 5) == 0), $urandom_range(0, 1) == 1,
                $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                4'($urandom_range(0, 3)));
        end

        // Saturation: stall counter via sustained load-use, then flush counter via branches
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 70000; i++) cyc(0, 0, 0, 1, 1, 0, 4'd2, 4'd0, 4'd2);
        idle(2);
        for (int i = 0; i < 300; i++) begin
            cyc(0, 0, 1, 0, 0, 0, 0, 0, 0);
            idle(1);
        end
        idle(2);

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected responses never compared, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
